codec_sample_sequencer: RTL
===========================

# codec_sample_sequencer

Controller between the audio codec's read port and the DFT sample input. It runs the codec pop handshake and mixes left and right into one signed mono sample. It can optionally average 2^DECIM_LOG2 frames, buffers results in a small FIFO, and offers them to the DFT on a valid/ready interface. The block replaces direct wiring of `read_ready` into the DFT. With it, the DFT back-pressures without overflowing the codec, and dropped frames are counted.

## Interface
- `N`, 16: output sample width, 8..25.
- `DECIM_LOG2`, 0: log2 of the number of frames averaged per output sample, 0..3.
- `FIFO_DEPTH`, 4: output FIFO entries, a power of 2 and at least 2.

Ports:
- `clk`  in  1: system clock, the 50 MHz domain.
- `rst`  in  1: reset, asynchronous, active-low.
- `enable`  in  1: sequencing enable.
- `read_ready`  in  1: codec has a frame available.
- `readdata_left`  in  24: codec left sample, signed.
- `readdata_right`  in  24: codec right sample, signed.
- `read`  out  1: codec pop strobe.
- `sample_out`  out  N: FIFO head, signed.
- `sample_valid`  out  1: FIFO non-empty.
- `sample_ready`  in  1: DFT accepts the head.
- `drop_count`  out  8: count of results discarded because the FIFO was full. Saturates at 255.

## Operation
- State machine, `IDLE -> READ -> SETTLE -> IDLE`.
  - `IDLE`: moves to `READ` when `read_ready && enable`.
  - `READ`: `read`=1 for exactly one cycle. Both data words are registered at the end of this cycle.
  - `SETTLE`: `read`=0 for one cycle, which gives the codec time to update `read_ready`. The accumulate and push happen here.
- Mixing: `sum` = sext25(L) + sext25(R).
- Accumulator width is 25+DECIM_LOG2. `frame_cnt` counts 0..2^DECIM_LOG2-1.
  - In `SETTLE`, `acc += sum` and `frame_cnt` increments.
  - On the last frame, `res` = (acc+sum) >>> DECIM_LOG2 (arithmetic), then truncated to 25 bits. The push value is `res[24:25-N]`, the top N bits with no rounding. `acc` and `frame_cnt` then clear.
- Push rules:
  - When the FIFO is not full, the push is accepted.
  - When the FIFO is full and no pop occurs in the same cycle, the result is discarded and `drop_count` increments, saturating at 255.
  - A simultaneous pop and push when full is accepted, and the count is unchanged.
- The codec is always popped while `enable`=1, even when the FIFO is full. The codec must never stall on this block.
- Pop occurs when `sample_valid && sample_ready`. The head advances on that edge.
- `enable` low:
  - A frame already in `READ` or `SETTLE` completes, including its accumulation.
  - In `IDLE` with `enable`=0, `acc` and `frame_cnt` clear, so no partial average survives a disable.
  - FIFO contents and `drop_count` are retained.
- Reset asserted mid-frame: everything returns to reset values immediately, and any partial accumulation is lost.

## Timing
- Reset values:
  - `read`=0, `sample_valid`=0, `sample_out`=0, `drop_count`=0.
  - State is `IDLE`, and `acc`, `frame_cnt` and the FIFO pointers are 0.
- `read` rises one cycle after `read_ready` is sampled high in `IDLE`.
- Minimum frame period is 3 cycles.
- Latency: the push is written at the end of `SETTLE`. `sample_valid` rises in the next cycle if the FIFO was empty. The total is 3 cycles from the `read_ready` sample edge to `sample_valid`.
- `sample_out` is registered. It is stable while `sample_valid && !sample_ready`.
- `read_ready` is ignored outside `IDLE`. If it stays high after `SETTLE`, the next frame starts immediately.

## Structure
- Package `cchw_audio_pkg`:
  - State enum `seq_state_t` with values `IDLE`, `READ`, `SETTLE`.
  - `CODEC_W`=24 and `MIX_W`=25.
  - Drop counter width of 8.
- Sub-module `sample_fifo`:
  - Parameterized by `W` and `DEPTH`.
  - Registered head, full and empty flags, and the push-when-full-with-pop rule.
- The state machine, mixer and accumulator live in the top module.

## Test plan
- Conversion, positive: `DECIM_LOG2`=0, N=16, L=R=0x100000, `sample_ready`=1. Expect one `read` pulse and `sample_out`=0x1000, with `sample_valid` high 3 cycles after `read_ready` is sampled.
- Conversion, negative: L=R=0xFFFFFF. Expect `sample_out`=0xFFFF. With L=0x800000 and R=0x7FFFFF, expect 0xFFFF.
- Averaging: `DECIM_LOG2`=2, four frames of L=R=0x000400. Expect exactly one output, 0x0004, after the 4th `SETTLE`, and no output after frames 1-3.
- Overflow: `sample_ready`=0, 6 frames with `FIFO_DEPTH`=4. Expect 6 `read` pulses, 4 entries held in order, and `drop_count`=2. Then with `sample_ready`=1, expect 4 pops and `sample_valid` to fall.
- Simultaneous push and pop: FIFO full, `sample_ready` pulsed during the `SETTLE` cycle. Expect the push accepted and `drop_count` unchanged.
- Disable and reset: deassert `enable` after 2 of 4 frames (`DECIM_LOG2`=2), then re-enable for 4 frames. Expect exactly one output from those 4 new frames. Asserting `rst` during `READ` must return all outputs to 0 the same cycle.

Source files
------------

// File: rtl/cchw_audio_pkg.sv
// rtl/cchw_audio_pkg.sv - shared types and widths for the codec sample path
package cchw_audio_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        SETTLE = 2'd2
    } seq_state_t;

    localparam int CODEC_W = 24;
    localparam int MIX_W   = 25;
    localparam int DROP_W  = 8;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - shift-register FIFO with registered head and full/empty flags
module sample_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_tvalid,
    input  logic [W-1:0] s_tdata,
    output logic [W-1:0] m_tdata,
    output logic         m_tvalid,
    input  logic         m_tready,
    output logic         overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [AW-1:0] wr_idx;
    logic          empty_q;
    logic          full_q;
    logic          pop;
    logic          push;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    always_comb begin
        pop        = !empty_q && m_tready;
        push       = s_tvalid && (!full_q || pop);
        overflow   = s_tvalid && full_q && !pop;
        count_next = count + CW'(push) - CW'(pop);
        wr_idx     = count[AW-1:0] - AW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
            end
            if (push) mem[wr_idx] <= s_tdata;
            count   <= count_next;
            empty_q <= (count_next == '0);
            full_q  <= (count_next == CW'(DEPTH));
        end
    end

    assign m_tdata  = mem[0];
    assign m_tvalid = !empty_q;

endmodule

// File: rtl/codec_sample_sequencer.sv
// rtl/codec_sample_sequencer.sv - codec pop sequencer, L/R mixer, decimating averager
module codec_sample_sequencer
    import cchw_audio_pkg::*;
#(
    parameter int N          = 16,
    parameter int DECIM_LOG2 = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               read_ready,
    input  logic [CODEC_W-1:0] readdata_left,
    input  logic [CODEC_W-1:0] readdata_right,
    output logic               read,
    output logic [N-1:0]       sample_out,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic [DROP_W-1:0]  drop_count
);

    localparam int AW = MIX_W + DECIM_LOG2;
    localparam int CW = (DECIM_LOG2 == 0) ? 1 : DECIM_LOG2;
    localparam logic [CW-1:0] LAST = CW'((1 << DECIM_LOG2) - 1);

    seq_state_t              state;
    logic [CODEC_W-1:0]      left_q;
    logic [CODEC_W-1:0]      right_q;
    logic [CW-1:0]           frame_cnt;
    logic signed [MIX_W-1:0] sum;
    logic signed [AW-1:0]    acc;
    logic signed [AW-1:0]    acc_next;
    logic signed [AW-1:0]    res;
    logic                    push;
    logic [N-1:0]            push_data;
    logic                    overflow;

    assign sum       = $signed({left_q[CODEC_W-1], left_q}) + $signed({right_q[CODEC_W-1], right_q});
    assign acc_next  = acc + AW'(sum);
    assign res       = acc_next >>> DECIM_LOG2;
    assign push      = (state == SETTLE) && (frame_cnt == LAST);
    assign push_data = res[MIX_W-1 -: N];
    assign read      = (state == READ);

    // The codec is popped regardless of FIFO space; a full FIFO only drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            left_q     <= '0;
            right_q    <= '0;
            acc        <= '0;
            frame_cnt  <= '0;
            drop_count <= '0;
        end else begin
            if (overflow) drop_count <= sat_inc(drop_count);
            case (state)
                IDLE: begin
                    if (!enable) begin
                        acc       <= '0;
                        frame_cnt <= '0;
                    end
                    if (read_ready && enable) state <= READ;
                end
                READ: begin
                    left_q  <= readdata_left;
                    right_q <= readdata_right;
                    state   <= SETTLE;
                end
                SETTLE: begin
                    if (frame_cnt == LAST) begin
                        acc       <= '0;
                        frame_cnt <= '0;
                    end else begin
                        acc       <= acc_next;
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    sample_fifo #(
        .W     (N),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst),
        .s_tvalid (push),
        .s_tdata  (push_data),
        .m_tdata  (sample_out),
        .m_tvalid (sample_valid),
        .m_tready (sample_ready),
        .overflow (overflow)
    );

endmodule
